sha512_block_sched: RTL
=======================

Name: sha512_block_sched

Overview:
- Read-side scheduler between the CCI-P c0 channel and the SHA-512 core.
- Issues 2-line (1024-bit) read requests, each tagged with a buffer slot in mdata, and tolerates out-of-order responses.
- Reassembles each response pair into one 1024-bit message block and delivers blocks to the core strictly in request order over a valid/ready handshake.
- Flow-controls reads by slot credits and reports job completion.

Parameters:
- SLOTS, 4, number of 1024-bit reassembly slots; power of 2, range 2..16; also the maximum number of outstanding requests.
- SLOT_W, $clog2(SLOTS), slot index width; derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins a job (accepted only in IDLE or DONE)
- buf_addr  in  42  t_ccip_clAddr of the first line of the source buffer
- num_lines  in  32  job length in cache lines; must be even
- c0_alm_full  in  1  c0TxAlmFull
- req_valid  out  1  c0 read request valid (registered)
- req_addr  out  42  request line address
- req_mdata  out  16  tag; [SLOT_W-1:0] = slot index, other bits 0
- rsp_valid  in  1  c0 rspValid && resp_type==eRSP_RDLINE
- rsp_mdata  in  16  response tag
- rsp_cl_num  in  2  line within the 2-line request
- rsp_data  in  512  response data
- blk_valid  out  1  block to core valid
- blk_data  out  1024  block; [511:0] from cl_num 0, [1023:512] from cl_num 1
- blk_last  out  1  final block of the job
- core_ready  in  1  core accepts a block when blk_valid && core_ready
- busy  out  1  state is RUN or DRAIN
- done  out  1  held high in DONE
- err  out  1  sticky; cleared by an accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; every slot FREE; all counters 0.
- Reset mid-job aborts the job. Responses arriving afterwards are ignored and do not set err.
- Slot states: FREE, PEND, FULL. Each slot has per-half valid bits h0 and h1.
- Head pointer hp: next slot delivered. Tail pointer tp: next slot requested. Both wrap mod SLOTS.
- FSM IDLE/DONE -> RUN on start:
  - Latch buf_addr and num_lines; clear req_idx, blk_cnt and err.
  - If num_lines==0: go to DONE next cycle, no requests.
  - If num_lines[0]==1: set err, go to DONE, no requests.
- RUN, issue condition: !c0_alm_full && slot[tp]==FREE && req_idx*2 < num_lines. When met:
  - Next cycle: req_valid=1, req_addr=buf_addr+2*req_idx (42-bit wrap), cl_len=eCL_LEN_2, req_mdata=tp.
  - slot[tp] becomes PEND; tp++ and req_idx++.
  - Otherwise req_valid=0.
  - Issue rate is at most one request per cycle.
- RUN -> DRAIN when req_idx*2 == num_lines.
- Response handling:
  - If slot[rsp_mdata[SLOT_W-1:0]] is PEND and the addressed half is not yet valid: write rsp_data into half rsp_cl_num[0] and set that half-valid bit.
  - When both halves are valid, the slot becomes FULL on the next cycle.
  - A response to a FREE or FULL slot, a duplicate half, or nonzero rsp_cl_num[1]: drop it and set err.
- Delivery:
  - blk_valid=1 while slot[hp]==FULL; blk_data comes from slot[hp] and is stable until transfer.
  - On blk_valid && core_ready: slot[hp] becomes FREE, half-valid bits clear, hp++ and blk_cnt++.
  - blk_last = blk_valid && (blk_cnt+1)*2 == num_lines.
  - Minimum latency from the second half response to blk_valid: 1 cycle.
- Simultaneous events:
  - Freeing slot[hp] and issuing into the same slot in the same cycle is not allowed; FREE becomes visible to the issuer the next cycle.
  - A response into one slot in the same cycle as delivery from another is legal.
- DRAIN -> DONE when blk_cnt*2 == num_lines. DONE holds done=1 until start.
- start while busy is ignored.

Decomposition:
- Shared package sha512_pkg gains:
  - t_sched_state {S_SC_IDLE, S_SC_RUN, S_SC_DRAIN, S_SC_DONE}
  - t_slot_state {SLOT_FREE, SLOT_PEND, SLOT_FULL}
  - t_rsm_slot {state, h0, h1, data[1023:0]}
- One sub-module: sha512_slot_buf (slot array, half writes, head/tail pointers, FREE/FULL status). The scheduler FSM and request issue stay in the top module.

Test Plan:
- start, buf_addr=0x1000, num_lines=8, in-order responses, core_ready=1 -> requests at 0x1000, 0x1002, 0x1004, 0x1006 with mdata 0..3; 4 blocks in order; blk_last on the 4th; done.
- num_lines=4, responses (tag1,cl1), (tag0,cl1), (tag1,cl0), (tag0,cl0) -> slot 1 fills first, yet block 0 is delivered before block 1, each with halves in the correct positions.
- num_lines=16, core_ready=0 -> exactly 4 requests issued, then stalls; raising core_ready resumes issue one free slot at a time; 8 blocks total.
- c0_alm_full=1 for 10 cycles in RUN -> req_valid=0 throughout; issue resumes the cycle after the deassert.
- num_lines=0 -> DONE with no requests and err=0. num_lines=3 -> DONE with err=1. Duplicate (tag0,cl0) response -> err=1 and data not overwritten.
- reset asserted with 2 requests outstanding, then their responses arrive -> blk_valid stays 0, err stays 0, state IDLE.

Source files
------------

// File: rtl/sha512_pkg.sv
// Shared SHA-512 types: scheduler FSM states, reassembly slot states and the slot record.
// Ports: none (package).
// Imported by the block scheduler and its slot buffer.
package sha512_pkg;

    typedef logic [41:0] t_ccip_clAddr;

    typedef enum logic [1:0] {
        S_SC_IDLE,
        S_SC_RUN,
        S_SC_DRAIN,
        S_SC_DONE
    } t_sched_state;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_PEND,
        SLOT_FULL
    } t_slot_state;

    // One 1024-bit reassembly slot; h0/h1 flag which 512-bit half has arrived.
    typedef struct packed {
        t_slot_state    state;
        logic           h0;
        logic           h1;
        logic [1023:0]  data;
    } t_rsm_slot;

endpackage

// File: rtl/sha512_slot_buf.sv
// Reassembly slot array: out-of-order half writes, in-order head delivery, tail allocation.
// Ports: issue_i claims slot[tp]; rsp_* write halves; deq_i frees slot[hp]; status/data outputs.
// Latency: a completing half write makes the slot FULL at the next edge; no backpressure of its own.
module sha512_slot_buf
    import sha512_pkg::*;
#(
    parameter int SLOTS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic                       issue_i,
    input  logic                       rsp_valid_i,
    input  logic [$clog2(SLOTS)-1:0]   rsp_slot_i,
    input  logic [1:0]                 rsp_cl_num_i,
    input  logic [511:0]               rsp_data_i,
    input  logic                       deq_i,
    output logic [$clog2(SLOTS)-1:0]   tp_o,
    output logic                       tp_free_o,
    output logic                       hp_full_o,
    output logic [1023:0]              hp_data_o,
    output logic                       rsp_err_o
);
    localparam int SLOT_W = $clog2(SLOTS);

    t_rsm_slot          slot_q [SLOTS];
    logic [SLOT_W-1:0]  hp_q;
    logic [SLOT_W-1:0]  tp_q;
    logic               rsp_half_set;
    logic               rsp_ok;
    logic               rsp_hit;

    assign rsp_half_set = rsp_cl_num_i[0] ? slot_q[rsp_slot_i].h1 : slot_q[rsp_slot_i].h0;
    // Only a pending slot with the addressed half still empty may be written.
    assign rsp_ok    = (slot_q[rsp_slot_i].state == SLOT_PEND) && !rsp_cl_num_i[1] && !rsp_half_set;
    assign rsp_hit   = en_i && rsp_valid_i && rsp_ok;
    assign rsp_err_o = en_i && rsp_valid_i && !rsp_ok;

    assign tp_o      = tp_q;
    assign tp_free_o = (slot_q[tp_q].state == SLOT_FREE);
    assign hp_full_o = (slot_q[hp_q].state == SLOT_FULL);
    assign hp_data_o = slot_q[hp_q].data;

    // Issue needs FREE, write needs PEND, dequeue needs FULL, so the three
    // updates below can never target the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hp_q <= '0;
            tp_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (issue_i) begin
                slot_q[tp_q].state <= SLOT_PEND;
                tp_q               <= tp_q + 1'b1;
            end
            if (rsp_hit) begin
                if (rsp_cl_num_i[0]) begin
                    slot_q[rsp_slot_i].data[1023:512] <= rsp_data_i;
                    slot_q[rsp_slot_i].h1             <= 1'b1;
                    if (slot_q[rsp_slot_i].h0) begin
                        slot_q[rsp_slot_i].state <= SLOT_FULL;
                    end
                end else begin
                    slot_q[rsp_slot_i].data[511:0] <= rsp_data_i;
                    slot_q[rsp_slot_i].h0          <= 1'b1;
                    if (slot_q[rsp_slot_i].h1) begin
                        slot_q[rsp_slot_i].state <= SLOT_FULL;
                    end
                end
            end
            if (deq_i) begin
                slot_q[hp_q].state <= SLOT_FREE;
                slot_q[hp_q].h0    <= 1'b0;
                slot_q[hp_q].h1    <= 1'b0;
                hp_q               <= hp_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha512_block_sched.sv
// CCI-P c0 read scheduler: issues 2-line reads tagged by slot, reassembles out-of-order halves,
// delivers 1024-bit blocks to the SHA-512 core in request order; reports busy/done/err.
// Ports: start/buf_addr/num_lines job setup; req_* c0 requests; rsp_* c0 responses; blk_* to core.
// Latency: request registered one cycle after issue; block valid one cycle after its last half.
// Backpressure: c0_alm_full and slot credits stall issue; core_ready stalls delivery.
module sha512_block_sched
    import sha512_pkg::*;
#(
    parameter int SLOTS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [41:0]   buf_addr,
    input  logic [31:0]   num_lines,
    input  logic          c0_alm_full,
    output logic          req_valid,
    output logic [41:0]   req_addr,
    output logic [15:0]   req_mdata,
    input  logic          rsp_valid,
    input  logic [15:0]   rsp_mdata,
    input  logic [1:0]    rsp_cl_num,
    input  logic [511:0]  rsp_data,
    output logic          blk_valid,
    output logic [1023:0] blk_data,
    output logic          blk_last,
    input  logic          core_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int SLOT_W = $clog2(SLOTS);

    t_sched_state   state_q;
    t_ccip_clAddr   buf_addr_q;
    logic [31:0]    num_lines_q;
    logic [31:0]    req_idx_q;
    logic [31:0]    blk_cnt_q;
    logic           err_q;
    logic           req_valid_q;
    t_ccip_clAddr   req_addr_q;
    logic [15:0]    req_mdata_q;

    logic               busy_w;
    logic               issue;
    logic               deq;
    logic               tp_free;
    logic               hp_full;
    logic               rsp_err;
    logic [SLOT_W-1:0]  tp;
    logic               unused_tag_bits;

    // Tag bits above the slot index are always zero on our requests.
    assign unused_tag_bits = ^rsp_mdata[15:SLOT_W];

    assign busy_w = (state_q == S_SC_RUN) || (state_q == S_SC_DRAIN);
    // Compare in 33 bits so req_idx*2 cannot overflow against num_lines.
    assign issue  = (state_q == S_SC_RUN) && !c0_alm_full && tp_free &&
                    ({req_idx_q, 1'b0} < {1'b0, num_lines_q});
    assign deq    = blk_valid && core_ready;

    assign blk_valid = busy_w && hp_full;
    assign blk_last  = blk_valid && ({blk_cnt_q + 32'd1, 1'b0} == {1'b0, num_lines_q});
    assign busy      = busy_w;
    assign done      = (state_q == S_SC_DONE);
    assign err       = err_q;
    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_mdata = req_mdata_q;

    sha512_slot_buf #(
        .SLOTS (SLOTS)
    ) u_slot_buf (
        .clk          (clk),
        .reset        (reset),
        .en_i         (busy_w),
        .issue_i      (issue),
        .rsp_valid_i  (rsp_valid),
        .rsp_slot_i   (rsp_mdata[SLOT_W-1:0]),
        .rsp_cl_num_i (rsp_cl_num),
        .rsp_data_i   (rsp_data),
        .deq_i        (deq),
        .tp_o         (tp),
        .tp_free_o    (tp_free),
        .hp_full_o    (hp_full),
        .hp_data_o    (blk_data),
        .rsp_err_o    (rsp_err)
    );

    // Requests are always 2-line (eCL_LEN_2); each covers lines 2*req_idx and 2*req_idx+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SC_IDLE;
            buf_addr_q  <= '0;
            num_lines_q <= '0;
            req_idx_q   <= '0;
            blk_cnt_q   <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mdata_q <= '0;
        end else begin
            req_valid_q <= issue;
            if (issue) begin
                req_addr_q  <= buf_addr_q + 42'({req_idx_q, 1'b0});
                req_mdata_q <= 16'(tp);
                req_idx_q   <= req_idx_q + 32'd1;
            end
            if (deq) begin
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
            if (rsp_err) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_SC_IDLE, S_SC_DONE: begin
                    if (start) begin
                        buf_addr_q  <= buf_addr;
                        num_lines_q <= num_lines;
                        req_idx_q   <= '0;
                        blk_cnt_q   <= '0;
                        // An odd length cannot be split into 2-line reads.
                        err_q       <= num_lines[0];
                        state_q     <= ((num_lines == 32'd0) || num_lines[0]) ? S_SC_DONE : S_SC_RUN;
                    end
                end
                S_SC_RUN: begin
                    if ({req_idx_q, 1'b0} == {1'b0, num_lines_q}) begin
                        state_q <= S_SC_DRAIN;
                    end
                end
                S_SC_DRAIN: begin
                    if ({blk_cnt_q, 1'b0} == {1'b0, num_lines_q}) begin
                        state_q <= S_SC_DONE;
                    end
                end
                default: state_q <= S_SC_IDLE;
            endcase
        end
    end

endmodule
